// File: rtl/out_port_arbiter_if.sv
// Signal bundle between the per-input packet senders and the output-port arbiter.
// The slave side is the arbiter; the master side is the sender/sink environment.
interface out_port_arbiter_if #(
    parameter int NREQ   = 4,
    parameter int UWIDTH = 8
);
    logic [NREQ-1:0]        req;
    logic [NREQ-1:0]        pkt_valid;
    logic [NREQ*UWIDTH-1:0] pkt_data;
    logic [NREQ-1:0]        gnt;
    logic                   out_valid;
    logic [UWIDTH-1:0]      out_data;
    logic                   out_sop;
    logic                   out_eop;
    logic                   out_err;
    logic                   busy;

    modport master (
        output req, pkt_valid, pkt_data,
        input  gnt, out_valid, out_data, out_sop, out_eop, out_err, busy
    );

    modport slave (
        input  req, pkt_valid, pkt_data,
        output gnt, out_valid, out_data, out_sop, out_eop, out_err, busy
    );
endinterface

// File: rtl/out_port_arbiter.sv
// Round-robin arbiter sharing one output link among NREQ packet senders, one whole packet per grant.
// Optional macro ARB_TIMEOUT_EN aborts a grant whose SRC byte does not arrive within TIMEOUT cycles.
//
// state | meaning
// IDLE  | no grant, arbitrating every cycle
// GRANT | grant held, waiting for the SRC byte
// XFER  | forwarding DST, SIZE, data and CRC bytes
// GAP   | one dead cycle after a packet, arbitrating
module out_port_arbiter #(
    parameter int NREQ      = 4,
    parameter int UWIDTH    = 8,
    parameter int SIZE_BITS = 3,
    parameter int TIMEOUT   = 15
) (
    input logic               clk,
    input logic               rst,
    out_port_arbiter_if.slave bus
);
    localparam int PTR_W = $clog2(NREQ);
    localparam int PW1   = PTR_W + 1;
    localparam int CNT_W = SIZE_BITS + 1;

    if (NREQ < 2 || NREQ > 8 || SIZE_BITS < 2 || SIZE_BITS > UWIDTH || TIMEOUT < 1) begin : g_bad_param
        $error("out_port_arbiter: unsupported parameter set");
    end

    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_XFER, S_GAP} state_t;

    state_t               state, state_nxt;
    logic [PTR_W-1:0]     ptr, ptr_nxt;
    logic [NREQ-1:0]      gnt, gnt_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    logic [SIZE_BITS-1:0] size, size_nxt;
    logic                 ov, ov_nxt, sop, sop_nxt, eop, eop_nxt, err, err_nxt;
    logic [UWIDTH-1:0]    od, od_nxt;

    logic                 arb_hit;
    logic [PTR_W-1:0]     arb_idx;
    logic [PTR_W:0]       cand;
    logic                 sel_valid;
    logic [UWIDTH-1:0]    sel_data;
    logic                 is_crc;

`ifdef ARB_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    logic [TMR_W-1:0]     tmr, tmr_nxt;
`endif

    // first requester at or above ptr, wrapping
    always_comb begin
        arb_hit = 1'b0;
        arb_idx = '0;
        cand    = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = {1'b0, ptr} + PW1'(i);
            if (cand >= PW1'(NREQ)) cand = cand - PW1'(NREQ);
            if (!arb_hit && bus.req[cand[PTR_W-1:0]]) begin
                arb_hit = 1'b1;
                arb_idx = cand[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NREQ; i++)
            sel_data = sel_data | (bus.pkt_data[i*UWIDTH +: UWIDTH] & {UWIDTH{gnt[i]}});
    end

    assign sel_valid = |(gnt & bus.pkt_valid);
    assign is_crc    = (cnt == ({1'b0, size} + CNT_W'(3)));

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        gnt_nxt   = gnt;
        cnt_nxt   = cnt;
        size_nxt  = size;
        ov_nxt    = 1'b0;
        od_nxt    = '0;
        sop_nxt   = 1'b0;
        eop_nxt   = 1'b0;
        err_nxt   = 1'b0;
`ifdef ARB_TIMEOUT_EN
        tmr_nxt   = tmr;
`endif
        case (state)
            S_IDLE, S_GAP: begin
                gnt_nxt   = '0;
                state_nxt = S_IDLE;
                if (arb_hit) begin
                    gnt_nxt[arb_idx] = 1'b1;
                    ptr_nxt   = (arb_idx == PTR_W'(NREQ - 1)) ? '0 : arb_idx + PTR_W'(1);
                    state_nxt = S_GRANT;
`ifdef ARB_TIMEOUT_EN
                    tmr_nxt   = TMR_W'(TIMEOUT);
`endif
                end
            end
            S_GRANT: begin
                if (sel_valid) begin
                    ov_nxt    = 1'b1;
                    od_nxt    = sel_data;
                    sop_nxt   = 1'b1;
                    cnt_nxt   = CNT_W'(1);
                    state_nxt = S_XFER;
                end
`ifdef ARB_TIMEOUT_EN
                else if (tmr <= TMR_W'(1)) begin
                    err_nxt   = 1'b1;
                    gnt_nxt   = '0;
                    state_nxt = S_GAP;
                end else begin
                    tmr_nxt   = tmr - TMR_W'(1);
                end
`endif
            end
            S_XFER: begin
                if (sel_valid) begin
                    ov_nxt  = 1'b1;
                    od_nxt  = sel_data;
                    cnt_nxt = cnt + CNT_W'(1);
                    if (cnt == CNT_W'(2)) size_nxt = sel_data[SIZE_BITS-1:0];
                    // size is already registered by index 3, the earliest possible CRC
                    if (is_crc) begin
                        eop_nxt   = 1'b1;
                        gnt_nxt   = '0;
                        cnt_nxt   = '0;
                        state_nxt = S_GAP;
                    end
                end else begin
                    err_nxt   = 1'b1;
                    gnt_nxt   = '0;
                    cnt_nxt   = '0;
                    state_nxt = S_GAP;
                end
            end
            default: begin
                gnt_nxt   = '0;
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
            ptr   <= '0;
            gnt   <= '0;
            cnt   <= '0;
            size  <= '0;
            ov    <= 1'b0;
            od    <= '0;
            sop   <= 1'b0;
            eop   <= 1'b0;
            err   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            tmr   <= '0;
`endif
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            gnt   <= gnt_nxt;
            cnt   <= cnt_nxt;
            size  <= size_nxt;
            ov    <= ov_nxt;
            od    <= od_nxt;
            sop   <= sop_nxt;
            eop   <= eop_nxt;
            err   <= err_nxt;
`ifdef ARB_TIMEOUT_EN
            tmr   <= tmr_nxt;
`endif
        end
    end

    assign bus.gnt       = gnt;
    assign bus.out_valid = ov;
    assign bus.out_data  = od;
    assign bus.out_sop   = sop;
    assign bus.out_eop   = eop;
    assign bus.out_err   = err;
    assign bus.busy      = (state != S_IDLE);
endmodule

// File: tb/tb_out_port_arbiter.sv
// Bench for out_port_arbiter: reactive sender models plus a packet-level round-robin reference.
// Define ARB_TIMEOUT_EN for both bench and design to include the grant timeout case.
module tb_out_port_arbiter;
    localparam int NREQ      = 4;
    localparam int UWIDTH    = 8;
    localparam int SIZE_BITS = 3;
    localparam int TIMEOUT   = 15;

    typedef struct {
        int sender;
        int len;
        int dly;
        int abort_at;   // -1: complete packet, else bytes sent before valid drops
        int base;
    } pkt_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    out_port_arbiter_if #(.NREQ(NREQ), .UWIDTH(UWIDTH)) bus ();

    out_port_arbiter #(
        .NREQ(NREQ), .UWIDTH(UWIDTH), .SIZE_BITS(SIZE_BITS), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int model_ptr = 0;
    bit noise_en = 1'b0;

    pkt_t       pk[$];
    logic [7:0] pbytes[$];
    int         sq[NREQ][$];
    int         cur_idx[NREQ];
    int         wait_cnt[NREQ];
    bit         active[NREQ];
    bit         fed[NREQ];

    logic [7:0]      cap_data[$];
    bit              cap_sop[$];
    bit              cap_eop[$];
    int              cap_t[$];
    int              gnt_t[$];
    int              gnt_who[$];
    int              err_t[$];
    logic [NREQ-1:0] gnt_prev = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int onehot_idx(input logic [NREQ-1:0] g);
        int r = -1;
        for (int i = NREQ - 1; i >= 0; i--) if (g[i]) r = i;
        return r;
    endfunction

    function automatic bit pending_any();
        for (int i = 0; i < NREQ; i++) if (sq[i].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drive_req();
        for (int i = 0; i < NREQ; i++) bus.req[i] = (sq[i].size() > 0);
    endtask

    task automatic add_pkt(input int s, input int size, input int dly, input int abort_at);
        pkt_t       q;
        logic [7:0] b;
        q.sender   = s;
        q.len      = size + 4;
        q.dly      = dly;
        q.abort_at = abort_at;
        q.base     = pbytes.size();
        for (int j = 0; j < size + 4; j++) begin
            b = 8'($urandom);
            if (j == 2) b = {b[7:3], 3'(size)};
            pbytes.push_back(b);
        end
        sq[s].push_back(pk.size());
        pk.push_back(q);
    endtask

    // one clock: sample outputs 1 time unit after the edge, then update the sender models
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (bus.out_valid) begin
            cap_data.push_back(bus.out_data);
            cap_sop.push_back(bus.out_sop);
            cap_eop.push_back(bus.out_eop);
            cap_t.push_back(cyc);
        end
        if (bus.out_err) begin
            err_t.push_back(cyc);
            check("err_with_gnt_low", bus.gnt, '0);
        end
        if (bus.gnt != '0) check("busy_while_granted", bus.busy, 1);
        if (bus.gnt != '0 && gnt_prev == '0) begin
            gnt_t.push_back(cyc);
            gnt_who.push_back(onehot_idx(bus.gnt));
            check("gnt_onehot", $onehot(bus.gnt), 1);
        end
        gnt_prev = bus.gnt;

        for (int i = 0; i < NREQ; i++) begin
            logic       v;
            logic [7:0] d;
            int         p;
            v = 1'b0;
            d = '0;
            if (active[i]) begin
                p = sq[i][0];
                if (fed[i]) cur_idx[i]++;
                if (cur_idx[i] == pk[p].len || !bus.gnt[i]) begin
                    void'(sq[i].pop_front());
                    active[i] = 1'b0;
                end
            end
            fed[i] = 1'b0;
            if (!active[i] && bus.gnt[i] && sq[i].size() > 0) begin
                active[i]   = 1'b1;
                cur_idx[i]  = 0;
                wait_cnt[i] = pk[sq[i][0]].dly;
            end
            if (active[i]) begin
                p = sq[i][0];
                if (wait_cnt[i] > 0) wait_cnt[i]--;
                else if (cur_idx[i] != pk[p].abort_at) begin
                    v      = 1'b1;
                    d      = pbytes[pk[p].base + cur_idx[i]];
                    fed[i] = 1'b1;
                end
            end else if (noise_en) begin
                v = 1'($urandom_range(0, 1));
                d = 8'($urandom);
            end
            bus.pkt_valid[i]                  = v;
            bus.pkt_data[i*UWIDTH +: UWIDTH]  = d;
            bus.req[i]                        = (sq[i].size() > 0);
        end
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            sq[i].delete();
            active[i] = 1'b0;
            fed[i]    = 1'b0;
        end
        bus.req       = '0;
        bus.pkt_valid = '0;
        step();
        step();
        check({tag, " gnt"},       bus.gnt, '0);
        check({tag, " out_valid"}, bus.out_valid, 0);
        check({tag, " out_data"},  bus.out_data, '0);
        check({tag, " out_sop"},   bus.out_sop, 0);
        check({tag, " out_eop"},   bus.out_eop, 0);
        check({tag, " out_err"},   bus.out_err, 0);
        check({tag, " busy"},      bus.busy, 0);
        rst = 1'b1;
        model_ptr = 0;
    endtask

    // runs all queued packets and compares against the packet-level round-robin model
    task automatic run_phase(input string tag, input int budget);
        int order[$];
        int plist[$];
        int rem[NREQ];
        int seen[NREQ];
        int total, ptr, start, bi, ai, last_end, exp_bytes, exp_err;
        cap_data.delete(); cap_sop.delete(); cap_eop.delete(); cap_t.delete();
        gnt_t.delete(); gnt_who.delete(); err_t.delete();

        total = 0;
        for (int i = 0; i < NREQ; i++) begin
            rem[i]  = sq[i].size();
            seen[i] = 0;
            total  += rem[i];
        end
        ptr = model_ptr;
        while (total > 0) begin
            for (int k = 0; k < NREQ; k++) begin
                int i;
                i = (ptr + k) % NREQ;
                if (rem[i] > 0) begin
                    order.push_back(i);
                    rem[i]--;
                    total--;
                    ptr = (i + 1) % NREQ;
                    break;
                end
            end
        end
        model_ptr = ptr;
        exp_bytes = 0;
        exp_err   = 0;
        foreach (order[n]) begin
            int pi;
            pi = sq[order[n]][seen[order[n]]];
            seen[order[n]]++;
            plist.push_back(pi);
            if (pk[pi].abort_at < 0) exp_bytes += pk[pi].len;
            else begin
                exp_bytes += pk[pi].abort_at;
                exp_err++;
            end
        end

        start = cyc;
        drive_req();
        while (pending_any() && (cyc - start) < budget) step();
        check({tag, " completed_in_budget"}, pending_any(), 0);
        repeat (2) step();

        check({tag, " grants"}, gnt_t.size(), order.size());
        check({tag, " bytes"},  cap_data.size(), exp_bytes);
        check({tag, " errs"},   err_t.size(), exp_err);

        bi = 0;
        ai = 0;
        last_end = start;
        for (int p = 0; p < plist.size(); p++) begin
            pkt_t q;
            int   emit, g;
            q    = pk[plist[p]];
            emit = (q.abort_at < 0) ? q.len : q.abort_at;
            if (p >= gnt_t.size()) break;
            g = gnt_t[p];
            check({tag, " grant_who"},  gnt_who[p], q.sender);
            check({tag, " grant_time"}, g, last_end + 1);
            for (int j = 0; j < emit; j++) begin
                if (bi >= cap_data.size()) break;
                check({tag, " data"},      cap_data[bi], pbytes[q.base + j]);
                check({tag, " sop"},       cap_sop[bi], (j == 0));
                check({tag, " eop"},       cap_eop[bi], (q.abort_at < 0) && (j == emit - 1));
                check({tag, " byte_time"}, cap_t[bi], g + 1 + q.dly + j);
                last_end = cap_t[bi];
                bi++;
            end
            if (q.abort_at >= 0) begin
                if (ai < err_t.size()) begin
                    check({tag, " err_time"}, err_t[ai],
                          (emit == 0) ? g + TIMEOUT : g + q.dly + emit + 1);
                    last_end = err_t[ai];
                end
                ai++;
            end
        end
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int p;
        bus.req       = '0;
        bus.pkt_valid = '0;
        bus.pkt_data  = '0;
        do_reset("reset0");

        // single 6-byte packet from requester 0
        add_pkt(0, 2, 0, -1);
        p = pk.size() - 1;
        pbytes[pk[p].base + 0] = 8'h01;
        pbytes[pk[p].base + 1] = 8'h02;
        pbytes[pk[p].base + 2] = 8'h02;
        pbytes[pk[p].base + 3] = 8'hA5;
        pbytes[pk[p].base + 4] = 8'h5A;
        pbytes[pk[p].base + 5] = 8'hC3;
        run_phase("t1", 200);
        check("t1 gnt_after", bus.gnt, '0);
        check("t1 busy_after", bus.busy, 0);

        // all four requesting, minimum-size packets
        do_reset("reset1");
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < NREQ; i++) add_pkt(i, 0, 0, -1);
        run_phase("t2", 400);

        // lone requester re-granted after each gap, maximum size
        for (int k = 0; k < 3; k++) add_pkt(2, 7, 0, -1);
        run_phase("t3", 400);

        // abort after DST, next requester follows
        add_pkt(0, 3, 0, 2);
        add_pkt(1, 1, 1, -1);
        run_phase("t4", 200);

        // reset during the data phase of a SIZE=5 packet
        add_pkt(1, 5, 0, -1);
        drive_req();
        for (int n = 0; n < 50 && !(active[1] && cur_idx[1] >= 4); n++) step();
        check("t5 reached_data_phase", cur_idx[1], 4);
        rst = 1'b0;
        step();
        check("t5 gnt",       bus.gnt, '0);
        check("t5 out_valid", bus.out_valid, 0);
        check("t5 out_data",  bus.out_data, '0);
        check("t5 out_sop",   bus.out_sop, 0);
        check("t5 out_eop",   bus.out_eop, 0);
        check("t5 out_err",   bus.out_err, 0);
        check("t5 busy",      bus.busy, 0);
        rst = 1'b1;
        model_ptr = 0;
        add_pkt(1, 2, 0, -1);
        add_pkt(3, 2, 0, -1);
        run_phase("t5 after_reset", 200);

        // randomized traffic with noise on idle senders and occasional aborts
        noise_en = 1'b1;
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < NREQ; i++) begin
                int n;
                n = $urandom_range(0, 3);
                for (int k = 0; k < n; k++) begin
                    int sz, ab;
                    sz = $urandom_range(0, 7);
                    ab = ($urandom_range(0, 7) == 0) ? $urandom_range(1, sz + 3) : -1;
                    add_pkt(i, sz, $urandom_range(0, 3), ab);
                end
            end
            run_phase("rand", 1000);
        end
        noise_en = 1'b0;

`ifdef ARB_TIMEOUT_EN
        // stuck requester 0 times out, requester 1 then served
        do_reset("reset_to");
        add_pkt(0, 2, 1000, 0);
        add_pkt(1, 1, 0, -1);
        run_phase("t6", 300);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/out_port_arbiter.md
# out_port_arbiter

Round-robin arbiter sharing one router output link between `NREQ` packet senders. It grants one requester at a time and holds the grant for one whole packet: SRC, DST, SIZE, `SIZE` data bytes, CRC. It forwards the granted sender's bytes through a registered mux and frames them with start-of-packet and end-of-packet markers. It sits between the per-input packet senders and the output-port FIFO.

## Interface
Parameters:
- `NREQ`, 4, number of requesters (2..8)
- `UWIDTH`, 8, byte width
- `SIZE_BITS`, 3, width of the SIZE field (low bits of header byte 2)
- `TIMEOUT`, 15, grant-to-first-byte limit in cycles (used only with `ARB_TIMEOUT_EN`)

Ports:
- `clk` in 1, sole clock, rising edge
- `rst` in 1, synchronous, active-low reset
- `req` in NREQ, per-requester "packet ready" level
- `pkt_valid` in NREQ, per-requester byte-valid
- `pkt_data` in NREQ*UWIDTH, per-requester byte; requester i uses bits [i*UWIDTH +: UWIDTH]
- `gnt` out NREQ, one-hot grant, registered
- `out_valid` out 1, output byte valid
- `out_data` out UWIDTH, output byte
- `out_sop` out 1, marks the SRC byte
- `out_eop` out 1, marks the CRC byte
- `out_err` out 1, one-cycle pulse on an aborted packet
- `busy` out 1, high in every state except IDLE

## Operation
- FSM states: IDLE, GRANT, XFER, GAP.
- **IDLE:** if any `req` is set, pick the first set bit scanning upward from `ptr` (wrapping). Register that bit one-hot into `gnt`, set `ptr = (winner+1) mod NREQ`, go to GRANT.
- **GRANT:** wait for `pkt_valid[g]`. That byte is SRC (index 0); go to XFER.
- **XFER:** one byte per cycle while `pkt_valid[g]` is high.
  - The byte counter counts index 0,1,2,...
  - At index 2, capture `size = byte[SIZE_BITS-1:0]`.
  - Packet length = size+4 bytes; size 0 is legal (4 bytes).
  - The byte at index size+3 is CRC: clear `gnt`, go to GAP.
- **GAP:** one cycle with no grant and no output. Arbitrate as in IDLE: go to GRANT if any `req` is set, else to IDLE. This guarantees the one-idle-cycle spacing the senders need between packets.
- **Abort:** `pkt_valid[g]` low in XFER before CRC. Pulse `out_err`, clear `gnt`, go to GAP. Do not emit `out_eop`.
- Bytes from non-granted requesters are ignored. `pkt_valid` on a requester that has no `req` set is ignored.
- Current holder still requesting at CRC: `ptr` already points past it, so other requesters win first. If it is the only requester, it is re-granted after GAP.
- Byte counter is `SIZE_BITS`+1 bits wide and cannot overflow for legal sizes.
- Reset (any cycle, including mid-packet):
  - `gnt`, `out_valid`, `out_data`, `out_sop`, `out_eop`, `out_err`, `busy` = 0
  - `ptr` = 0, state = IDLE, counter and `size` = 0
  - A packet cut by reset is dropped without `out_err`.

## Timing
- `req` sampled at edge t → `gnt` high after edge t.
- Accepted byte at edge k appears on `out_data`/`out_valid` after edge k (one-cycle registered latency). `out_sop`/`out_eop` align with their byte.
- CRC accepted at edge k → `gnt` low after k; GAP during cycle k+1; earliest new `gnt` after edge k+1.
- Back-to-back packets therefore have exactly one dead output cycle between `out_eop` and the next `out_sop`, plus the grant-to-first-byte latency of the new sender.
- `out_err` pulses in the cycle after the abort is detected, aligned with `gnt` dropping.

## Configuration
- `ARB_TIMEOUT_EN` defined:
  - A counter runs in GRANT.
  - If `pkt_valid[g]` has not arrived after `TIMEOUT` cycles, pulse `out_err`, clear `gnt`, go to GAP. `ptr` is already advanced, so a stuck requester cannot starve the others.
- Undefined: GRANT waits indefinitely; the counter and `TIMEOUT` logic are absent.

## Test plan
- Reset then `req`=0001; sender 0 sends SRC=1, DST=2, SIZE=2, D0, D1, CRC → 6 output bytes, `out_sop` on byte 1, `out_eop` on byte 6, `gnt` low after CRC.
- `req`=1111 held; every packet SIZE=0 → grants in order 0,1,2,3,0; exactly one idle output cycle between consecutive packets.
- Only requester 2 requesting continuously, SIZE=7 → re-granted after each one-cycle GAP; 11 bytes per packet.
- Mid-packet `pkt_valid` drop after DST → `out_err` one cycle, no `out_eop`, next requester granted after GAP.
- `rst` low during a SIZE=5 data phase → all outputs 0 next cycle, `ptr`=0; after release, `req`=1010 grants requester 1 first.
- With `ARB_TIMEOUT_EN`, TIMEOUT=15: grant requester 0, no `pkt_valid` → `out_err` after 15 GRANT cycles, then requester 1 granted.
